// File: rtl/spart_pkg.sv
// Shared SPART constants: rx state encoding, frame geometry
// and the bus-interface ioaddr codes.
package spart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int HALF       = OVERSAMPLE / 2;
  localparam int TICK_W     = $clog2(OVERSAMPLE);
  localparam int BIT_W      = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_e;

  typedef enum logic [1:0] {
    IOADDR_BUF    = 2'b00,
    IOADDR_STATUS = 2'b01,
    IOADDR_DB_LO  = 2'b10,
    IOADDR_DB_HI  = 2'b11
  } ioaddr_e;

  // True on the n-th brg_en tick of a count that starts at 0.
  function automatic logic nth_tick(
    input logic [TICK_W-1:0] t,
    input int                n
  );
    return t == TICK_W'(n - 1);
  endfunction

endpackage

// File: rtl/spart_rx_if.sv
// Bus-side bundle between the SPART bus interface and the rx path.
// master: bus interface (drives clr_rda); slave: receiver.
interface spart_rx_if;
  import spart_pkg::*;

  logic                 clr_rda;
  logic [DATA_BITS-1:0] databus;
  logic                 rda;
  logic                 framing_err;
  logic                 overrun;

  modport master (
    output clr_rda,
    input  databus,
    input  rda,
    input  framing_err,
    input  overrun
  );

  modport slave (
    input  clr_rda,
    output databus,
    output rda,
    output framing_err,
    output overrun
  );

endinterface

// File: rtl/spart_sync2.sv
// Generic 2-flop synchroniser for asynchronous inputs.
// Ports: clk, rst (async, active-high), d (async in), q (synced out).
module spart_sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spart_rx.sv
// SPART receive path: 8N1 deserialiser on 16x brg_en oversampling.
// Ports: clk, rst (async high), brg_en, rxd, bus (spart_rx_if.slave).
module spart_rx
  import spart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       brg_en,
  input  logic       rxd,
  spart_rx_if.slave  bus
);

  logic                 rxd_s;
  rx_state_e            state;
  logic [TICK_W-1:0]    tick;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 rda_q;
  logic                 fe_q;
  logic                 ov_q;

  spart_sync2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      data_q  <= '0;
      rda_q   <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      // Clear first; a same-cycle stop event below overrides it.
      if (bus.clr_rda) begin
        rda_q <= 1'b0;
        fe_q  <= 1'b0;
        ov_q  <= 1'b0;
      end
      if (brg_en) begin
        unique case (state)
          IDLE: begin
            if (!rxd_s) begin
              tick  <= '0;
              state <= START;
            end
          end
          START: begin
            tick <= tick + 1'b1;
            if (nth_tick(tick, HALF)) begin
              if (!rxd_s) begin
                tick    <= '0;
                bit_cnt <= '0;
                state   <= DATA;
              end else begin
                state <= IDLE;
              end
            end
          end
          DATA: begin
            tick <= tick + 1'b1;
            if (nth_tick(tick, OVERSAMPLE)) begin
              shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_W'(DATA_BITS - 1))
                state <= STOP;
            end
          end
          STOP: begin
            tick <= tick + 1'b1;
            if (nth_tick(tick, OVERSAMPLE)) begin
              state <= IDLE;
              if (rxd_s) begin
                data_q <= shreg;
                rda_q  <= 1'b1;
                if (rda_q && !bus.clr_rda)
                  ov_q <= 1'b1;
              end else begin
                fe_q <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.databus     = data_q;
  assign bus.rda         = rda_q;
  assign bus.framing_err = fe_q;
  assign bus.overrun     = ov_q;

endmodule
